// File: rtl/sha_mmio_seq.sv
// sha_mmio_seq: memory-mapped front end for a hash core.
//
// Takes message blocks word by word over a simple bus, buffers up to
// FIFO_DEPTH full blocks, and feeds them to the core with init/next pulses
// from an autonomous sequencer. The final digest is latched and readable.
// Sticky done/err status, a level interrupt and per-field locks are included.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clr_i                synchronous clear (same as CTRL.soft_clear, also clears irq_en)
//   acct_en_i            bus accesses are ignored while low
//   lock_i[3:0]          [0] CTRL wr, [1] BLOCK_IN wr, [2] digest rd, [3] STATUS rd locks
//   en_i, we_i, addr_i   bus strobe, write enable, byte address
//   wdata_i, rdata_o     bus write data, combinational read data
//   core_init_o/next_o   one-cycle block-issue pulses to the core
//   core_block_o         FIFO head block
//   core_ready_i, core_digest_i, core_digest_valid_i   core handshake/result
//   busy_o               sequencer is working on a message
//   irq_o                done & irq_en
//
// Register map (word index = addr_i[7:ADDR_LSB]):
//   0 CTRL   : wr b0 start, b1 last, b2 soft_clear, b3 irq_en, b4 clr done, b5 clr err
//   1 STATUS : {blocks_done[15:0], 4'b0, fifo_count[3:0], 4'b0, err, done, busy, fifo_full}
//   2 BLOCK_IN (write only)
//   3..      : digest words, word k = digest[k*DATA_W +: DATA_W]
module sha_mmio_seq #(
  parameter int DATA_W     = 64,
  parameter int BLOCK_W    = 512,
  parameter int DIGEST_W   = 256,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_LSB   = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                acct_en_i,
  input  logic [3:0]          lock_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [7:0]          addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                core_init_o,
  output logic                core_next_o,
  output logic [BLOCK_W-1:0]  core_block_o,
  input  logic                core_ready_i,
  input  logic [DIGEST_W-1:0] core_digest_i,
  input  logic                core_digest_valid_i,
  output logic                busy_o,
  output logic                irq_o
);

  localparam int WPB      = BLOCK_W / DATA_W;
  localparam int DWORDS   = DIGEST_W / DATA_W;
  localparam int WC_W     = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W    = 8 - ADDR_LSB;
  localparam int IDX_CTRL = 0;
  localparam int IDX_STAT = 1;
  localparam int IDX_BLK  = 2;
  localparam int IDX_DIG0 = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ACK, S_WAIT, S_STALL, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 irq_en_q, irq_en_d;
  logic [15:0]          blocks_done_q, blocks_done_d;
  logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic [BLOCK_W-1:0]   staging_q, staging_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DIGEST_W-1:0]  digest_q, digest_d;

  logic [BLOCK_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic [IDX_W-1:0]     word_idx;
  logic                 bus_wr, ctrl_hit, blk_hit, ctrl_wr, blk_wr, lock_err;
  logic                 soft_clear, do_clear, start;
  logic                 blk_last, push_req, push_ok, pop, fifo_full, busy;
  logic                 mem_we, enter_done;
  logic [BLOCK_W-1:0]   staging_merge;
  logic [31:0]          status_w;
  logic [DATA_W-1:0]    digest_word [DWORDS];
  logic                 addr_lsb_unused;

  // Byte-lane address bits below the word index carry no meaning here.
  assign addr_lsb_unused = ^addr_i[ADDR_LSB-1:0];

  for (genvar gi = 0; gi < DWORDS; gi++) begin : g_dig
    assign digest_word[gi] = digest_q[gi*DATA_W +: DATA_W];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------- bus decode ----------------
  assign word_idx   = addr_i[7:ADDR_LSB];
  assign bus_wr     = en_i && acct_en_i && we_i;
  assign ctrl_hit   = bus_wr && (word_idx == IDX_W'(IDX_CTRL));
  assign blk_hit    = bus_wr && (word_idx == IDX_W'(IDX_BLK));
  assign ctrl_wr    = ctrl_hit && !lock_i[0];
  assign blk_wr     = blk_hit && !lock_i[1];
  assign lock_err   = (ctrl_hit && lock_i[0]) || (blk_hit && lock_i[1]);
  assign soft_clear = ctrl_wr && wdata_i[2];
  assign do_clear   = clr_i || soft_clear;
  assign start      = ctrl_wr && wdata_i[0];

  // ---------------- FIFO control ----------------
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign blk_last  = blk_wr && (word_cnt_q == WC_W'(WPB - 1));
  assign push_req  = blk_last;
  assign pop       = (state_q == S_ISSUE) && core_ready_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign mem_we    = push_ok && !do_clear;

  always_comb begin
    staging_merge = staging_q;
    staging_merge[word_cnt_q*DATA_W +: DATA_W] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) fifo_mem[wr_ptr_q] <= staging_merge;
  end

  // ---------------- outputs ----------------
  assign core_init_o  = pop && first_q;
  assign core_next_o  = pop && !first_q;
  assign core_block_o = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
  assign busy_o       = busy;
  assign irq_o        = done_q && irq_en_q;

  assign status_w = {blocks_done_q, 4'h0, 4'(count_q), 4'h0, err_q, done_q, busy, fifo_full};

  always_comb begin
    rdata_o = '0;
    if (en_i && acct_en_i && !we_i) begin
      if (word_idx == IDX_W'(IDX_STAT) && !lock_i[3]) rdata_o = DATA_W'(status_w);
      for (int k = 0; k < DWORDS; k++) begin
        if (!lock_i[2] && word_idx == IDX_W'(IDX_DIG0 + k)) rdata_o = digest_word[k];
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    last_d        = last_q;
    done_d        = done_q;
    err_d         = err_q;
    irq_en_d      = irq_en_q;
    blocks_done_d = blocks_done_q;
    word_cnt_d    = word_cnt_q;
    staging_d     = staging_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    digest_d      = digest_q;
    enter_done    = 1'b0;

    if (do_clear) begin
      // Clearing drops any in-flight core result: the FSM leaves WAIT
      // before the digest could be latched.
      state_d       = S_IDLE;
      first_d       = 1'b0;
      last_d        = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      blocks_done_d = '0;
      word_cnt_d    = '0;
      staging_d     = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      digest_d      = '0;
      if (clr_i)        irq_en_d = 1'b0;
      else if (ctrl_wr) irq_en_d = wdata_i[3];
    end else begin
      if (ctrl_wr) begin
        irq_en_d = wdata_i[3];
        if (wdata_i[1]) last_d = 1'b1;
        if (wdata_i[4]) done_d = 1'b0;
        if (wdata_i[5]) err_d  = 1'b0;
      end

      if (blk_wr) begin
        staging_d  = staging_merge;
        word_cnt_d = blk_last ? '0 : word_cnt_q + WC_W'(1);
      end

      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            first_d       = 1'b1;
            blocks_done_d = '0;
            done_d        = 1'b0;
            state_d       = (count_q != '0) ? S_ISSUE : S_STALL;
          end
        end
        S_ISSUE: begin
          if (pop) begin
            first_d = 1'b0;
            state_d = S_ACK;
          end
        end
        S_ACK: state_d = S_WAIT;
        S_WAIT: begin
          if (core_ready_i && core_digest_valid_i) begin
            if (blocks_done_q != 16'hFFFF) blocks_done_d = blocks_done_q + 16'd1;
            if (count_q != '0) state_d = S_ISSUE;
            else if (last_q)   enter_done = 1'b1;
            else               state_d = S_STALL;
          end
        end
        S_STALL: begin
          if (count_q != '0) state_d = S_ISSUE;
          else if (last_q)   enter_done = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase

      if (enter_done) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        last_d   = 1'b0;
        digest_d = core_digest_i;
      end

      if (lock_err || (push_req && !push_ok) || (start && busy)) err_d = 1'b1;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      irq_en_q      <= 1'b0;
      blocks_done_q <= '0;
      word_cnt_q    <= '0;
      staging_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      digest_q      <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      last_q        <= last_d;
      done_q        <= done_d;
      err_q         <= err_d;
      irq_en_q      <= irq_en_d;
      blocks_done_q <= blocks_done_d;
      word_cnt_q    <= word_cnt_d;
      staging_q     <= staging_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      digest_q      <= digest_d;
    end
  end

endmodule

// File: tb/tb_sha_mmio_seq.sv
// Directed testbench for sha_mmio_seq (DATA_W=32, FIFO_DEPTH=2).
// A small core stub returns the known SHA-256 digests for the reference
// messages ("abc", and the two-block 448-bit message) and a fixed digest
// for any other block.
module tb_sha_mmio_seq;

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_BLK  = 8'h08;
  localparam logic [7:0] A_DW0  = 8'h0C;
  localparam logic [7:0] A_DW3  = 8'h18;
  localparam logic [7:0] A_DW7  = 8'h28;

  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] BLK_B1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_B2  = {{15{32'h00000000}}, 32'h000001c0};
  localparam logic [511:0] BLK_G   = {16{32'hA5A50F0F}};
  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_GEN   = 256'h0badf00d_11111111_22222222_33333333_44444444_55555555_66666666_13579bdf;

  logic         clk = 1'b0;
  logic         rst_n, clr, acct_en, en, we;
  logic [3:0]   lock;
  logic [7:0]   addr;
  logic [31:0]  wdata, rdata;
  logic         core_init, core_next, core_ready, core_valid, busy, irq;
  logic [511:0] core_block;
  logic [255:0] core_digest, core_res;
  int           core_lat, cnt;
  logic         b1;
  int           n_init = 0, n_next = 0;
  int           n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  sha_mmio_seq #(
    .DATA_W(32), .BLOCK_W(512), .DIGEST_W(256), .FIFO_DEPTH(2), .ADDR_LSB(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .acct_en_i(acct_en), .lock_i(lock),
    .en_i(en), .we_i(we), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
    .core_init_o(core_init), .core_next_o(core_next), .core_block_o(core_block),
    .core_ready_i(core_ready), .core_digest_i(core_digest),
    .core_digest_valid_i(core_valid), .busy_o(busy), .irq_o(irq)
  );

  // Core stub: drops ready after a pulse, returns a result core_lat cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready <= 1'b1; core_valid <= 1'b0; core_digest <= '0;
      core_res <= '0; cnt <= 0; b1 <= 1'b0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0; core_valid <= 1'b0; cnt <= core_lat;
      if (core_init) begin
        core_res <= (core_block == BLK_ABC) ? D_ABC : D_GEN;
        b1 <= (core_block == BLK_B1);
      end else begin
        core_res <= (b1 && core_block == BLK_B2) ? D_TWO : D_GEN;
        b1 <= 1'b0;
      end
    end else if (!core_ready) begin
      if (cnt == 0) begin
        core_ready <= 1'b1; core_valid <= 1'b1; core_digest <= core_res;
      end else cnt <= cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (core_init) n_init++;
    if (core_next) n_next++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %-14s got=%h expected=%h", tag, got, exp);
    end else $display("ok   %-14s = %h", tag, got);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    en = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, {32'h0, v}, {32'h0, exp});
  endtask

  task automatic load(input logic [511:0] b);
    for (int n = 0; n < 16; n++) wr(A_BLK, b[n*32 +: 32]);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rd(A_STAT, s);
      if (s[2]) begin seen = 1'b1; break; end
    end
    check(tag, {63'h0, seen}, 64'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, x0;
    rst_n = 1'b0; clr = 1'b0; acct_en = 1'b1; lock = 4'h0;
    en = 1'b0; we = 1'b0; addr = 8'h0; wdata = 32'h0; core_lat = 4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    rd_check("rst_status", A_STAT, 32'h0);
    rd_check("rst_dig0", A_DW0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-block "abc"
    i0 = n_init; x0 = n_next;
    load(BLK_ABC);
    wr(A_CTRL, 32'h3);
    wait_done("abc_done");
    check("abc_inits", 64'(n_init - i0), 64'd1);
    check("abc_nexts", 64'(n_next - x0), 64'd0);
    rd_check("abc_dig7", A_DW7, 32'hba7816bf);
    rd_check("abc_dig0", A_DW0, 32'hf20015ad);
    rd_check("abc_status", A_STAT, 32'h0001_0004);
    check("abc_irq", {63'h0, irq}, 64'h0);

    // Two-block message, both buffered before start, interrupt enabled
    wr(A_CTRL, 32'h4);
    load(BLK_B1);
    load(BLK_B2);
    rd_check("two_fifo", A_STAT, 32'h0000_0201);
    i0 = n_init; x0 = n_next;
    wr(A_CTRL, 32'hB);
    wait_done("two_done");
    check("two_inits", 64'(n_init - i0), 64'd1);
    check("two_nexts", 64'(n_next - x0), 64'd1);
    rd_check("two_dig7", A_DW7, 32'h248d6a61);
    rd_check("two_dig3", A_DW3, 32'ha33ce459);
    rd_check("two_dig0", A_DW0, 32'h19db06c1);
    rd_check("two_status", A_STAT, 32'h0002_0004);
    check("two_irq", {63'h0, irq}, 64'h1);

    // Overflow: third block dropped
    wr(A_CTRL, 32'h4);
    check("clr_irq", {63'h0, irq}, 64'h0);
    load(BLK_G); load(BLK_G); load(BLK_G);
    rd_check("ovf_status", A_STAT, 32'h0000_0209);

    // Start with empty FIFO -> STALL; busy start -> err
    wr(A_CTRL, 32'h4);
    i0 = n_init;
    wr(A_CTRL, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_busy", {63'h0, busy}, 64'h1);
    check("stall_inits", 64'(n_init - i0), 64'd0);
    rd_check("stall_status", A_STAT, 32'h0000_0002);
    wr(A_CTRL, 32'h1);
    rd_check("busy_start", A_STAT, 32'h0000_000A);
    wr(A_CTRL, 32'h20);
    rd_check("err_clear", A_STAT, 32'h0000_0002);
    load(BLK_G);
    wr(A_CTRL, 32'h2);
    wait_done("stall_done");
    rd_check("stall_fin", A_STAT, 32'h0001_0004);
    check("stall_inits2", 64'(n_init - i0), 64'd1);
    rd_check("gen_dig0", A_DW0, 32'h13579bdf);

    // Locks
    lock = 4'b0110;
    rd_check("lock_dig0", A_DW0, 32'h0);
    rd_check("lock_stat", A_STAT, 32'h0001_0004);
    wr(A_BLK, 32'h1234);
    rd_check("lock_blk_err", A_STAT, 32'h0001_000C);
    lock = 4'b0000;
    rd_check("unlock_dig0", A_DW0, 32'h13579bdf);
    wr(A_CTRL, 32'h20);
    rd_check("lock_errclr", A_STAT, 32'h0001_0004);
    lock = 4'b0001;
    wr(A_CTRL, 32'h10);
    rd_check("lock_ctrl", A_STAT, 32'h0001_000C);
    lock = 4'b1000;
    rd_check("lock_stat_rd", A_STAT, 32'h0);
    lock = 4'b0000;

    // Writes with access control disabled are ignored
    wr(A_CTRL, 32'h4);
    acct_en = 1'b0;
    wr(A_CTRL, 32'h1);
    acct_en = 1'b1;
    check("acct_busy", {63'h0, busy}, 64'h0);
    rd_check("acct_status", A_STAT, 32'h0);

    // Soft clear while waiting on the core
    core_lat = 20;
    load(BLK_G);
    i0 = n_init;
    wr(A_CTRL, 32'h3);
    repeat (4) @(posedge clk);
    #1;
    check("wait_busy", {63'h0, busy}, 64'h1);
    check("wait_inits", 64'(n_init - i0), 64'd1);
    wr(A_CTRL, 32'h4);
    check("sclr_busy", {63'h0, busy}, 64'h0);
    repeat (30) @(posedge clk);
    #1;
    rd_check("sclr_dig0", A_DW0, 32'h0);
    rd_check("sclr_status", A_STAT, 32'h0);

    // Asynchronous reset mid-message
    core_lat = 4;
    load(BLK_G);
    wr(A_CTRL, 32'hB);
    @(posedge clk);
    #2;
    check("pre_rst_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_init", {63'h0, core_init}, 64'h0);
    check("arst_block", {63'h0, |core_block}, 64'h0);
    rd_check("arst_status", A_STAT, 32'h0);
    rd_check("arst_dig0", A_DW0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_mmio_seq.md
Name: sha_mmio_seq

Overview:
- Second-generation memory-mapped front end for the tile's hash cores, replacing the single-block register wrapper.
- Sits between the AXI-lite slave interface (address/en/we/data side) and a hash core with the init/next/block/ready/digest/digest_valid handshake.
- Adds a parametrised multi-block FIFO, an autonomous init/next sequencer, a latched digest, sticky error/done status, an interrupt, and per-field register locks.
- Generalised in bus width, block width, digest width and FIFO depth.

Parameters:
- DATA_W, 64, bus data width; 32 or 64.
- BLOCK_W, 512, core block width; must be a multiple of DATA_W.
- DIGEST_W, 256, core digest width; must be a multiple of DATA_W.
- FIFO_DEPTH, 2, number of full blocks buffered; power of two, at least 1.
- ADDR_LSB, 3, lowest decoded address bit; 2 when DATA_W=32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear; same effect as CTRL.soft_clear
- acct_en_i  in  1  access-control enable; en_i is ignored when low
- lock_i  in  4  [0] CTRL write lock, [1] BLOCK_IN write lock, [2] digest read lock, [3] STATUS read lock
- en_i  in  1  bus access strobe
- we_i  in  1  write enable
- addr_i  in  8  byte address; word index = addr_i[7:ADDR_LSB]
- wdata_i  in  DATA_W  write data
- rdata_o  out  DATA_W  combinational read data
- core_init_o  out  1  one-cycle pulse: first block of a message
- core_next_o  out  1  one-cycle pulse: subsequent block
- core_block_o  out  BLOCK_W  FIFO head block
- core_ready_i  in  1  core idle
- core_digest_i  in  DIGEST_W  core digest
- core_digest_valid_i  in  1  core digest valid
- busy_o  out  1  FSM not in IDLE/DONE
- irq_o  out  1  level interrupt = done & irq_en

Behaviour:
- Reset (rst_ni low, asynchronous), clr_i, or CTRL.soft_clear:
  - clears FIFO, staging register, word counter, done, err, last, digest latch and irq_en (irq_en is not cleared by soft_clear).
  - FSM returns to IDLE; all outputs read 0.
- Word index map:
  - 0 CTRL: write bit0 start, bit1 last, bit2 soft_clear, bit3 irq_en. Write 1 to bit4 clears done; write 1 to bit5 clears err.
  - 1 STATUS, read only: {blocks_done[15:0] at bits 31:16, fifo_count at 11:8, err 3, done 2, busy 1, fifo_full 0}.
  - 2 BLOCK_IN, write only.
  - 3.. 3+DIGEST_W/DATA_W-1: digest words; word k = digest[k*DATA_W +: DATA_W].
  - All other indices read 0.
- BLOCK_IN writes: word n fills staging[n*DATA_W +: DATA_W].
  - On the BLOCK_W/DATA_W-th write, staging is pushed to the FIFO the same cycle and the counter wraps to 0.
  - If that push would overflow the FIFO: block dropped, err set, counter still wraps.
- Locked writes are ignored and set err. Locked reads return 0 with no error. Writes with acct_en_i low are ignored silently.
- FSM states: IDLE, ISSUE, ACK, WAIT, STALL, DONE.
  - IDLE: start written -> first=1, blocks_done=0, done=0. Then ISSUE if FIFO non-empty, else STALL.
  - ISSUE: if core_ready_i, pulse init (first=1) or next for 1 cycle with core_block_o = head; pop head; clear first; go to ACK. Otherwise hold.
  - ACK: one cycle (core drops ready) -> WAIT.
  - WAIT: core_ready_i && core_digest_valid_i -> blocks_done++. Then ISSUE if FIFO non-empty; else DONE if last; else STALL.
  - STALL: FIFO non-empty -> ISSUE; else last set -> DONE.
  - DONE: digest latched on entry, done=1, last cleared. start -> as from IDLE.
- last may be written at any time during a message; it takes effect only once the FIFO is empty.
- start while busy is ignored and sets err.
- Simultaneous push and pop in the same cycle: count is unchanged; full does not block.
- Clear during WAIT: FSM goes to IDLE; the in-flight core result is discarded, never latched.
- blocks_done saturates at 0xFFFF.

Test Plan:
- Load 16 words of padded "abc" (DATA_W=32), write CTRL=0x3 -> one init pulse, done=1, digest word 7 = 0xba7816bf, word 0 = 0xf20015ad, blocks_done=1.
- 2-block padded "abcdbcdecdefdefg..." (448-bit), both loaded before start, last written -> init then next, digest = 248d6a61...19db06c1, blocks_done=2, irq_o=1 when irq_en=1.
- FIFO_DEPTH=2: push 3 blocks with no start -> third dropped, err=1, fifo_count=2, fifo_full=1.
- start with empty FIFO -> STALL, busy=1, no pulses; push block then write last -> completes, done=1.
- lock_i=4'b0110 -> BLOCK_IN write ignored with err=1; digest reads 0 while STATUS still readable.
- soft_clear during WAIT -> busy=0 next cycle; a later core_digest_valid_i is ignored, digest stays 0; rst_ni low mid-message -> all outputs 0 asynchronously.
